// File: rtl/prog_fir_pkg.sv
// Shared types and constants for the programmable-FIR coefficient loader.
package prog_fir_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Field positions inside the 32-bit load_chan software register.
  localparam int LC_TRIG_BIT = 31;
  localparam int LC_CLR_BIT  = 30;
  localparam int LC_CHAN_MSB = 29;

  // Width of the completed-load counter.
  localparam int LOAD_CNT_W = 16;

  // Rising-edge test between the current and the previous sample of one bit.
  function automatic logic rose(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/prog_fir_rd_pipe.sv
// Delay line that follows each staging-RAM read through the RAM's read
// latency, so the write side knows when data is valid and which tap it is.
module prog_fir_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAP_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [TAP_W-1:0] i_tap,
  output logic             o_valid,
  output logic [TAP_W-1:0] o_tap
);

  // Element 0 is the pipe input; element gi+1 is the output of stage gi.
  logic [RD_LAT:0]  w_valid_chain;
  logic [TAP_W-1:0] w_tap_chain [RD_LAT+1];

  assign w_valid_chain[0] = i_valid;
  assign w_tap_chain[0]   = i_tap;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic             r_valid;
      logic [TAP_W-1:0] r_tap;

      // One register stage of {valid, tap}; cleared at once on reset so no
      // stale write survives an aborted load.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_valid <= 1'b0;
          r_tap   <= '0;
        end else begin
          r_valid <= w_valid_chain[gi];
          r_tap   <= w_tap_chain[gi];
        end
      end

      assign w_valid_chain[gi+1] = r_valid;
      assign w_tap_chain[gi+1]   = r_tap;
    end
  endgenerate

  assign o_valid = w_valid_chain[RD_LAT];
  assign o_tap   = w_tap_chain[RD_LAT];

endmodule

// File: rtl/prog_fir_coeff_loader.sv
// Copies one channel's coefficients from the shared staging RAM into the
// programmable-FIR coefficient RAM when software raises the load trigger.
module prog_fir_coeff_loader
  import prog_fir_pkg::*;
#(
  parameter int N_TAPS = 32,
  parameter int TAP_W  = 5,
  parameter int N_CHAN = 256,
  parameter int CH_W   = 8,
  parameter int COEF_W = 18,
  parameter int RD_LAT = 2
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [31:0]           load_chan,
  output logic [TAP_W-1:0]      stage_addr,
  input  logic [COEF_W-1:0]     stage_data,
  output logic                  coef_we,
  output logic [CH_W+TAP_W-1:0] coef_addr,
  output logic [COEF_W-1:0]     coef_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  bad_chan,
  output logic [LOAD_CNT_W-1:0] load_count
);

  localparam logic [TAP_W-1:0]       LAST_TAP   = TAP_W'(N_TAPS - 1);
  localparam logic [LC_CHAN_MSB:0]   N_CHAN_LIM = (LC_CHAN_MSB + 1)'(N_CHAN);

  // Input register and edge detector.
  logic [31:0] r_lc;
  logic        r_trig_prev;
  logic        r_clr_prev;
  logic        r_lc_vld;
  logic        r_prev_vld;
  logic        w_trig;
  logic        w_clr;
  logic        w_chan_ok;

  // Sequencer.
  state_t          r_state;
  state_t          w_state_next;
  logic            w_start;
  logic            w_overrun_set;
  logic            w_bad_set;
  logic [TAP_W-1:0] r_tap;
  logic [CH_W-1:0]  r_chan;

  // Status.
  logic                  r_overrun;
  logic                  r_bad_chan;
  logic [LOAD_CNT_W-1:0] r_load_count;

  // Read-tracking pipe outputs.
  logic             w_wr_valid;
  logic [TAP_W-1:0] w_wr_tap;
  logic             w_last_wr;

  // Register load_chan and remember the previous trigger/clear bits. The two
  // valid flags keep edges masked until two genuine post-reset samples exist,
  // so a bit held high across reset never looks like a new edge.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_lc        <= '0;
      r_trig_prev <= 1'b0;
      r_clr_prev  <= 1'b0;
      r_lc_vld    <= 1'b0;
      r_prev_vld  <= 1'b0;
    end else begin
      r_lc        <= load_chan;
      r_trig_prev <= r_lc[LC_TRIG_BIT];
      r_clr_prev  <= r_lc[LC_CLR_BIT];
      r_lc_vld    <= 1'b1;
      r_prev_vld  <= r_lc_vld;
    end
  end

  assign w_trig    = r_prev_vld & rose(r_lc[LC_TRIG_BIT], r_trig_prev);
  assign w_clr     = r_prev_vld & rose(r_lc[LC_CLR_BIT], r_clr_prev);
  // The whole channel field is range-checked, not just the addressing bits.
  assign w_chan_ok = (r_lc[LC_CHAN_MSB:0] < N_CHAN_LIM);

  // State register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the start and flag-set strobes.
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_overrun_set = 1'b0;
    w_bad_set     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        // DONE lasts exactly one cycle, but may chain straight into a new load.
        w_state_next = IDLE;
        if (w_trig) begin
          if (w_chan_ok) begin
            w_state_next = ISSUE;
            w_start      = 1'b1;
          end else begin
            w_bad_set = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_overrun_set = w_trig;
        if (r_tap == LAST_TAP) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_overrun_set = w_trig;
        // Leave once the final tap's write is on the coefficient bus.
        if (w_last_wr) begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Read address counter: steps through every tap while issuing and rests at
  // zero otherwise (the natural wrap after the last tap returns it to zero).
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_tap <= '0;
    end else if (r_state == ISSUE) begin
      r_tap <= r_tap + TAP_W'(1);
    end else begin
      r_tap <= '0;
    end
  end

  // Capture the target channel when a load is accepted; only the addressing
  // bits are kept since the range check already happened.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_chan <= '0;
    end else if (w_start) begin
      r_chan <= r_lc[CH_W-1:0];
    end
  end

  // Sticky error flags; a set event in the same cycle as a clear wins.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_overrun  <= 1'b0;
      r_bad_chan <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (w_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_bad_set) begin
        r_bad_chan <= 1'b1;
      end else if (w_clr) begin
        r_bad_chan <= 1'b0;
      end
    end
  end

  // Completed-load counter, wrapping naturally at its width.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_load_count <= '0;
    end else if (r_state == DONE) begin
      r_load_count <= r_load_count + LOAD_CNT_W'(1);
    end
  end

  prog_fir_rd_pipe #(
    .RD_LAT (RD_LAT),
    .TAP_W  (TAP_W)
  ) u_rd_pipe (
    .i_clk   (user_clk),
    .i_rst   (user_rst),
    .i_valid (r_state == ISSUE),
    .i_tap   (r_tap),
    .o_valid (w_wr_valid),
    .o_tap   (w_wr_tap)
  );

  assign w_last_wr = w_wr_valid && (w_wr_tap == LAST_TAP);

  assign stage_addr = r_tap;
  assign coef_we    = w_wr_valid;
  // The write bus is held at zero between writes.
  assign coef_addr  = w_wr_valid ? {r_chan, w_wr_tap} : '0;
  assign coef_data  = w_wr_valid ? stage_data : '0;
  assign busy       = (r_state == ISSUE) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign overrun    = r_overrun;
  assign bad_chan   = r_bad_chan;
  assign load_count = r_load_count;

endmodule

// File: tb/tb_prog_fir_coeff_loader.sv
// Self-checking bench: two loaders (read latency 2 and 1) share a staging
// RAM image; expected writes and done pulses are queued when triggers are
// issued and popped by per-instance monitors.
module tb_prog_fir_coeff_loader;

  localparam int N_TAPS = 32;
  localparam int TAP_W  = 5;
  localparam int N_CHAN = 200;
  localparam int CH_W   = 8;
  localparam int COEF_W = 18;
  localparam int N_INST = 2;

  typedef struct {
    int                    cyc;
    logic [CH_W+TAP_W-1:0] addr;
    logic [COEF_W-1:0]     data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0]           lc      [N_INST];
  logic [COEF_W-1:0]     mem     [N_TAPS];
  logic [TAP_W-1:0]      sa_a    [N_INST];
  logic                  we_a    [N_INST];
  logic [CH_W+TAP_W-1:0] addr_a  [N_INST];
  logic [COEF_W-1:0]     data_a  [N_INST];
  logic                  busy_a  [N_INST];
  logic                  done_a  [N_INST];
  logic                  ovr_a   [N_INST];
  logic                  bad_a   [N_INST];
  logic [15:0]           cnt_a   [N_INST];

  wr_t exp_q  [N_INST][$];
  int  done_q [N_INST][$];

  int   model_cnt [N_INST];
  logic model_ovr [N_INST];
  logic model_bad [N_INST];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_INST; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 2 : 1;
      logic [TAP_W-1:0]  p [LAT];
      logic [COEF_W-1:0] sd;
      wr_t               e;
      int                dexp;

      // Staging RAM with LAT-cycle registered read.
      always @(posedge clk) begin
        p[0] <= sa_a[gi];
        for (int j = 1; j < LAT; j++) p[j] <= p[j-1];
      end
      assign sd = mem[p[LAT-1]];

      prog_fir_coeff_loader #(
        .N_TAPS (N_TAPS), .TAP_W (TAP_W), .N_CHAN (N_CHAN),
        .CH_W (CH_W), .COEF_W (COEF_W), .RD_LAT (LAT)
      ) u_dut (
        .user_clk   (clk),
        .user_rst   (rst),
        .load_chan  (lc[gi]),
        .stage_addr (sa_a[gi]),
        .stage_data (sd),
        .coef_we    (we_a[gi]),
        .coef_addr  (addr_a[gi]),
        .coef_data  (data_a[gi]),
        .busy       (busy_a[gi]),
        .done       (done_a[gi]),
        .overrun    (ovr_a[gi]),
        .bad_chan   (bad_a[gi]),
        .load_count (cnt_a[gi])
      );

      // Monitor: compare every write and done pulse against the scoreboard.
      always @(negedge clk) begin
        tests++;
        if (we_a[gi]) begin
          if (exp_q[gi].size() == 0) begin
            fails++;
            $display("FAIL write inst%0d cyc=%0d unexpected addr=%h data=%h",
                     gi, cyc, addr_a[gi], data_a[gi]);
          end else begin
            e = exp_q[gi].pop_front();
            if (e.cyc != cyc || e.addr != addr_a[gi] || e.data != data_a[gi]) begin
              fails++;
              $display("FAIL write inst%0d got cyc=%0d addr=%h data=%h exp cyc=%0d addr=%h data=%h",
                       gi, cyc, addr_a[gi], data_a[gi], e.cyc, e.addr, e.data);
            end
          end
        end else if (addr_a[gi] != '0 || data_a[gi] != '0) begin
          fails++;
          $display("FAIL idle_bus inst%0d cyc=%0d got addr=%h data=%h exp 0",
                   gi, cyc, addr_a[gi], data_a[gi]);
        end
        if (done_a[gi]) begin
          tests++;
          if (done_q[gi].size() == 0) begin
            fails++;
            $display("FAIL done inst%0d cyc=%0d unexpected pulse", gi, cyc);
          end else begin
            dexp = done_q[gi].pop_front();
            if (dexp != cyc) begin
              fails++;
              $display("FAIL done inst%0d got cyc=%0d exp cyc=%0d", gi, cyc, dexp);
            end
          end
        end
      end
    end
  endgenerate

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc=%0d got %0h exp %0h", name, inst, cyc, got, exp);
    end
  endtask

  task automatic chk_status(input int i);
    chk("overrun", i, 32'(ovr_a[i]), 32'(model_ovr[i]));
    chk("bad_chan", i, 32'(bad_a[i]), 32'(model_bad[i]));
    chk("load_count", i, 32'(cnt_a[i]), 32'(model_cnt[i] % 65536));
  endtask

  task automatic set_lc(input int mask, input logic [31:0] v);
    for (int i = 0; i < N_INST; i++) if (mask[i]) lc[i] = v;
  endtask

  // Reference: a valid load writes every tap in order, starting two cycles
  // after the trigger plus the read latency, then pulses done.
  task automatic expect_load(input int i, input int chan, input int t0);
    wr_t w;
    logic [CH_W-1:0]  c8;
    logic [TAP_W-1:0] k5;
    c8 = CH_W'(chan);
    for (int k = 0; k < N_TAPS; k++) begin
      k5     = TAP_W'(k);
      w.cyc  = t0 + 2 + k + lat_of(i);
      w.addr = {c8, k5};
      w.data = mem[k];
      exp_q[i].push_back(w);
    end
    done_q[i].push_back(t0 + 2 + N_TAPS + lat_of(i));
    model_cnt[i]++;
  endtask

  task automatic model_trigger(input int mask, input int chan, input int t0);
    for (int i = 0; i < N_INST; i++) begin
      if (mask[i]) begin
        if (chan < N_CHAN) expect_load(i, chan, t0);
        else model_bad[i] = 1'b1;
      end
    end
  endtask

  // Drop bit 31 for a cycle, then raise it; returns the rising cycle.
  task automatic trigger(input int mask, input int chan, output int t0);
    logic [29:0] c30;
    c30 = 30'(chan);
    set_lc(mask, {2'b00, c30});
    tick(1);
    set_lc(mask, {2'b10, c30});
    t0 = cyc;
    model_trigger(mask, chan, t0);
  endtask

  task automatic do_clear();
    for (int i = 0; i < N_INST; i++) lc[i] = lc[i] | 32'h4000_0000;
    tick(1);
    for (int i = 0; i < N_INST; i++) chk_status(i);
    tick(1);
    for (int i = 0; i < N_INST; i++) begin
      model_ovr[i] = 1'b0;
      model_bad[i] = 1'b0;
      chk_status(i);
      lc[i] = lc[i] & 32'hBFFF_FFFF;
    end
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exceeded time budget", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int d;
    int chan;
    int off;
    for (int i = 0; i < N_INST; i++) begin
      model_cnt[i] = 0;
      model_ovr[i] = 1'b0;
      model_bad[i] = 1'b0;
      lc[i] = 32'h8000_0003;
    end
    for (int k = 0; k < N_TAPS; k++) mem[k] = COEF_W'(32'h100 + k);

    // Reset and priming: trigger bit held high across reset release.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick(1);
      for (int i = 0; i < N_INST; i++) chk("prime_busy", i, 32'(busy_a[i]), 32'd0);
    end
    for (int i = 0; i < N_INST; i++) begin
      chk_status(i);
      chk("prime_stage_addr", i, 32'(sa_a[i]), 32'd0);
    end

    // Normal load of channel 3 with ramp coefficients.
    trigger(3, 3, t0);
    tick(1);
    for (int i = 0; i < N_INST; i++) chk("busy_c1", i, 32'(busy_a[i]), 32'd0);
    tick(1);
    for (int i = 0; i < N_INST; i++) begin
      chk("busy_c2", i, 32'(busy_a[i]), 32'd1);
      chk("stage_addr_c2", i, 32'(sa_a[i]), 32'd0);
    end
    tick(5);
    for (int i = 0; i < N_INST; i++) chk("stage_addr_c7", i, 32'(sa_a[i]), 32'd5);
    tick(40);
    for (int i = 0; i < N_INST; i++) chk_status(i);

    // Overrun: retrigger at cycle 10 of a load, then clear.
    for (int k = 0; k < N_TAPS; k++) mem[k] = COEF_W'($urandom);
    trigger(3, 5, t0);
    tick(5);
    set_lc(3, 32'h0000_0005);
    tick(5);
    set_lc(3, 32'h8000_0005);
    for (int i = 0; i < N_INST; i++) model_ovr[i] = 1'b1;
    tick(40);
    for (int i = 0; i < N_INST; i++) chk_status(i);
    do_clear();

    // Bad channels: out of range, and huge value with in-range low bits.
    trigger(3, 250, t0);
    for (int n = 0; n < 10; n++) begin
      tick(1);
      for (int i = 0; i < N_INST; i++) chk("bad_busy", i, 32'(busy_a[i]), 32'd0);
    end
    for (int i = 0; i < N_INST; i++) chk_status(i);
    trigger(3, 32'h3FFF_FF05, t0);
    tick(10);
    for (int i = 0; i < N_INST; i++) chk_status(i);
    do_clear();

    // Reset in the middle of a load.
    chan = $urandom_range(0, N_CHAN - 1);
    trigger(3, chan, t0);
    tick(20);
    rst = 1'b1;
    #1;
    for (int i = 0; i < N_INST; i++) begin
      exp_q[i].delete();
      done_q[i].delete();
      model_cnt[i] = 0;
      model_ovr[i] = 1'b0;
      model_bad[i] = 1'b0;
      chk("rst_we", i, 32'(we_a[i]), 32'd0);
      chk("rst_busy", i, 32'(busy_a[i]), 32'd0);
      chk("rst_done", i, 32'(done_a[i]), 32'd0);
      chk("rst_stage_addr", i, 32'(sa_a[i]), 32'd0);
      chk("rst_coef_addr", i, 32'(addr_a[i]), 32'd0);
      chk_status(i);
    end
    tick(3);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < N_INST; i++) chk("rst_prime_busy", i, 32'(busy_a[i]), 32'd0);
    trigger(3, 7, t0);
    tick(45);
    for (int i = 0; i < N_INST; i++) chk_status(i);

    // Back-to-back: second trigger seen in the DONE cycle, one instance at a time.
    for (int i = 0; i < N_INST; i++) begin
      for (int k = 0; k < N_TAPS; k++) mem[k] = COEF_W'($urandom);
      trigger(1 << i, 9, t0);
      d = t0 + 2 + N_TAPS + lat_of(i);
      tick(5);
      set_lc(1 << i, 32'h0000_0009);
      tick(d - 1 - cyc);
      set_lc(1 << i, 32'h8000_000B);
      t1 = cyc;
      model_trigger(1 << i, 11, t1);
      tick(1);
      chk("b2b_done", i, 32'(done_a[i]), 32'd1);
      chk("b2b_busy_done", i, 32'(busy_a[i]), 32'd0);
      tick(1);
      chk("b2b_busy_next", i, 32'(busy_a[i]), 32'd1);
      chk("b2b_stage_addr", i, 32'(sa_a[i]), 32'd0);
      tick(40);
      chk_status(i);
    end

    // Randomized loads with optional retrigger and clear.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N_TAPS; k++) mem[k] = COEF_W'($urandom);
      chan = $urandom_range(0, 255);
      trigger(3, chan, t0);
      if (chan < N_CHAN && $urandom_range(0, 1) == 1) begin
        off = $urandom_range(3, 30);
        tick(2);
        set_lc(3, 32'(chan));
        tick(off - 2);
        set_lc(3, 32'h8000_0000 | 32'(chan));
        for (int i = 0; i < N_INST; i++) model_ovr[i] = 1'b1;
        tick(45 - off);
      end else begin
        tick(45);
      end
      set_lc(3, 32'(chan));
      tick($urandom_range(1, 5));
      for (int i = 0; i < N_INST; i++) chk_status(i);
      if ($urandom_range(0, 1) == 1) do_clear();
    end

    tick(5);
    for (int i = 0; i < N_INST; i++) begin
      chk("writes_left", i, 32'(exp_q[i].size()), 32'd0);
      chk("done_left", i, 32'(done_q[i].size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_fir_coeff_loader.md
Name: prog_fir_coeff_loader

Overview:
Consumes the 32-bit prog_fir "load_chan" software-register output in the user_clk domain. On a software trigger it copies one channel's N_TAPS coefficients from a shared staging BRAM into that channel's slot of the programmable-FIR coefficient RAM. Sits between the ppc2simulink load_chan register and the FIR coefficient memory. Reports busy, done, error flags and a load counter for software readback.

Parameters:
N_TAPS, 32, taps per channel; power of 2.
TAP_W, 5, log2(N_TAPS).
N_CHAN, 256, number of channels; need not be a power of 2.
CH_W, 8, ceil(log2(N_CHAN)).
COEF_W, 18, coefficient width.
RD_LAT, 2, staging RAM read latency in cycles, 1..4.

Ports:
user_clk  in  1  fabric clock.
user_rst  in  1  asynchronous, active-high reset.
load_chan  in  32  register value: [31] load trigger, [30] flag clear, [29:0] channel.
stage_addr  out  TAP_W  staging RAM read address.
stage_data  in  COEF_W  staging RAM read data, valid RD_LAT cycles after address.
coef_we  out  1  coefficient RAM write enable.
coef_addr  out  CH_W+TAP_W  {channel, tap}.
coef_data  out  COEF_W  coefficient write data.
busy  out  1  load in progress.
done  out  1  one-cycle pulse when a load completes.
overrun  out  1  sticky: trigger received while busy.
bad_chan  out  1  sticky: trigger with channel >= N_CHAN.
load_count  out  16  completed loads, wraps 0xFFFF->0.

Behaviour:
- Reset (async, active-high): every output 0; FSM to IDLE; edge detector unprimed.
- load_chan is registered once on entry. Edges are detected on the registered value against its previous sample.
- Priming: the first sample after reset release only initialises the edge detector. A bit held high across reset causes no trigger.
- Trigger = 0->1 on bit 31. Clear = 0->1 on bit 30.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE or DONE, trigger with channel < N_CHAN: latch the channel, go to ISSUE.
- IDLE or DONE, trigger with channel >= N_CHAN: set bad_chan, stay idle, no writes.
- ISSUE: stage_addr counts 0..N_TAPS-1, one per cycle. After N_TAPS-1, go to DRAIN.
- DRAIN: wait until the last write has been issued, then go to DONE.
- DONE: lasts one cycle; done=1, busy=0, load_count increments. Go to IDLE, or to ISSUE if a valid trigger arrives in this cycle.
- busy = 1 in ISSUE and DRAIN only.
- Timing, with bit 31 rising in cycle 0:
  - busy=1 and stage_addr=0 in cycle 2.
  - stage_addr=k in cycle 2+k.
  - coef_we=1 with coef_addr={chan,k} and coef_data=stage_data in cycle 2+k+RD_LAT.
  - done in cycle 2+N_TAPS+RD_LAT. With defaults: writes in cycles 4..35, done in cycle 36.
- A valid-bit plus tap-index delay line of depth RD_LAT tracks outstanding reads.
- coef_we is asserted exactly N_TAPS times per load, with contiguous taps in ascending order.
- coef_addr and coef_data are 0 whenever coef_we=0.
- Trigger while busy: ignored and overrun set. The current load is unaffected.
- Clear edge: overrun and bad_chan go to 0 the next cycle. If a set event occurs in the same cycle, set wins.
- Reset mid-load: immediate abort, no done, load_count=0. Coefficients already written stay in the RAM.
- Channel field: the full [29:0] is compared against N_CHAN. Only [CH_W-1:0] is used for addressing.

Decomposition:
- Package prog_fir_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - constants LC_TRIG_BIT=31, LC_CLR_BIT=30, LC_CHAN_MSB=29;
  - load_count width 16.
- One sub-module, prog_fir_rd_pipe: an RD_LAT-deep shift register of {valid, tap} with async reset.

Test Plan:
- Reset and priming: hold load_chan=0x8000_0003 through reset release for 50 cycles -> all outputs 0, no coef_we, load_count=0.
- Normal load: staging RAM holds 0x100+k; drive 0x0000_0003 then 0x8000_0003 -> 32 writes in cycles 4..35 with coef_addr=0x060+k and data 0x100+k; done in cycle 36; load_count=1.
- Overrun and clear: trigger channel 5, then drop and re-raise bit 31 in cycle 10 -> exactly 32 writes, overrun=1, load_count=1. Then raise bit 30 -> overrun=0 the next cycle.
- Bad channel (N_CHAN=200): trigger channel 250 -> bad_chan=1, busy never asserted, no writes, load_count unchanged.
- Reset mid-load: assert user_rst in cycle 20 -> all outputs 0 asynchronously, no done. After release, a fresh trigger on channel 7 -> full 32 writes, load_count=1.
- Back-to-back and RD_LAT=1: trigger arrives in the DONE cycle -> second load starts the next cycle, load_count=2. With RD_LAT=1: writes in cycles 3..34, done in cycle 35.
